// File: rtl/decoder_pkg.sv
// Shared widths and types for the 3-to-8 decoder slice.
package decoder_pkg;
  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef logic [OUT_W-1:0] onehot8_t;
endpackage

// File: rtl/decoder_2to4.sv
// Combinational 2-to-4 one-hot decoder; the enable becomes the selected bit.
module decoder_2to4 (
  input  logic       en,
  input  logic [1:0] select,
  output logic [3:0] data
);

  always_comb begin
    data         = 4'b0000;
    data[select] = en;
  end

endmodule

// File: rtl/decoder_3to8_reg.sv
// 3-to-8 one-hot decoder built from two 2-to-4 halves, with an optional
// output register (OUT_REG=1) cleared by a synchronous active-high reset.
module decoder_3to8_reg
  import decoder_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] s,
  output onehot8_t         data,
  output logic             valid
);

  logic     en_lo;
  logic     en_hi;
  onehot8_t dec;

  // s[2] steers the enable so at most one half can drive a bit high.
  assign en_lo = en & ~s[2];
  assign en_hi = en & s[2];

  decoder_2to4 u_dec_lo (
    .en     (en_lo),
    .select (s[1:0]),
    .data   (dec[3:0])
  );

  decoder_2to4 u_dec_hi (
    .en     (en_hi),
    .select (s[1:0]),
    .data   (dec[7:4])
  );

  generate
    if (OUT_REG != 0) begin : g_reg
      onehot8_t data_q;
      logic     valid_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= dec;
          valid_q <= en;
        end
      end

      assign data  = data_q;
      assign valid = valid_q;
    end else begin : g_comb
      logic unused_clk_reset;

      assign unused_clk_reset = &{1'b0, clk, reset};
      assign data             = dec;
      assign valid            = en;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Directed bench for the registered and combinational builds of the decoder
// and for the 2-to-4 building block.
module tb_decoder_3to8_reg;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] s;
  logic [7:0] data_r;
  logic       valid_r;
  logic [7:0] data_c;
  logic       valid_c;
  logic       sub_en;
  logic [1:0] sub_sel;
  logic [3:0] sub_data;

  int checks = 0;
  int passed = 0;

  decoder_3to8_reg #(.OUT_REG(1)) dut_reg (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .s     (s),
    .data  (data_r),
    .valid (valid_r)
  );

  decoder_3to8_reg #(.OUT_REG(0)) dut_comb (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .s     (s),
    .data  (data_c),
    .valid (valid_c)
  );

  decoder_2to4 dut_sub (
    .en     (sub_en),
    .select (sub_sel),
    .data   (sub_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] s;
    logic [7:0] exp_reg;
    logic       exp_rvalid;
    logic [7:0] exp_comb;
  } vec_t;

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic [3:0] exp;
  } sub_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  vec_t     vecs[19];
  sub_vec_t svecs[8];

  initial begin
    // reset with en=1 held for two cycles
    vecs[0]  = '{1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 8'h20};
    vecs[1]  = '{1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 8'h20};
    // sweep s = 0..7
    vecs[2]  = '{1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 8'h01};
    vecs[3]  = '{1'b0, 1'b1, 3'd1, 8'h02, 1'b1, 8'h02};
    vecs[4]  = '{1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 8'h04};
    vecs[5]  = '{1'b0, 1'b1, 3'd3, 8'h08, 1'b1, 8'h08};
    vecs[6]  = '{1'b0, 1'b1, 3'd4, 8'h10, 1'b1, 8'h10};
    vecs[7]  = '{1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 8'h20};
    vecs[8]  = '{1'b0, 1'b1, 3'd6, 8'h40, 1'b1, 8'h40};
    vecs[9]  = '{1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 8'h80};
    // disable, then re-enable at the same select
    vecs[10] = '{1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 3'd6, 8'h40, 1'b1, 8'h40};
    // mid-stream reset
    vecs[12] = '{1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 8'h80};
    vecs[13] = '{1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 8'h80};
    vecs[14] = '{1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 8'h04};
    // boundary hops across the s[2] split
    vecs[15] = '{1'b0, 1'b1, 3'd3, 8'h08, 1'b1, 8'h08};
    vecs[16] = '{1'b0, 1'b1, 3'd4, 8'h10, 1'b1, 8'h10};
    vecs[17] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    vecs[18] = '{1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 8'h00};

    svecs[0] = '{1'b1, 2'd0, 4'b0001};
    svecs[1] = '{1'b1, 2'd1, 4'b0010};
    svecs[2] = '{1'b1, 2'd2, 4'b0100};
    svecs[3] = '{1'b1, 2'd3, 4'b1000};
    svecs[4] = '{1'b0, 2'd0, 4'b0000};
    svecs[5] = '{1'b0, 2'd1, 4'b0000};
    svecs[6] = '{1'b0, 2'd2, 4'b0000};
    svecs[7] = '{1'b0, 2'd3, 4'b0000};

    reset   = 1'b1;
    en      = 1'b0;
    s       = 3'd0;
    sub_en  = 1'b0;
    sub_sel = 2'd0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      en    = vecs[i].en;
      s     = vecs[i].s;
      #1;
      check($sformatf("comb_data[%0d]", i), {24'h0, data_c}, {24'h0, vecs[i].exp_comb});
      check($sformatf("comb_valid[%0d]", i), {31'h0, valid_c}, {31'h0, vecs[i].en});
      @(posedge clk);
      #1;
      check($sformatf("reg_data[%0d]", i), {24'h0, data_r}, {24'h0, vecs[i].exp_reg});
      check($sformatf("reg_valid[%0d]", i), {31'h0, valid_r}, {31'h0, vecs[i].exp_rvalid});
      check($sformatf("reg_onehot[%0d]", i), {31'h0, ($countones(data_r) <= 1)}, 32'h1);
    end

    // registered output must hold between edges while inputs move
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    s     = 3'd1;
    @(posedge clk);
    #1;
    s = 3'd6;
    #2;
    check("reg_hold_between_edges", {24'h0, data_r}, 32'h02);
    check("comb_follows_between_edges", {24'h0, data_c}, 32'h40);
    @(posedge clk);
    #1;
    check("reg_after_mid_cycle_change", {24'h0, data_r}, 32'h40);

    // combinational build ignores reset and clock activity
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    s     = 3'd3;
    #1;
    check("comb_ignores_reset", {24'h0, data_c}, 32'h08);
    @(posedge clk);
    #1;
    check("comb_after_edge_in_reset", {24'h0, data_c}, 32'h08);
    check("reg_cleared_in_reset", {24'h0, data_r}, 32'h00);

    // en=0 with unknown select still yields all-zero
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    s     = 3'bxxx;
    #1;
    check("comb_en0_sel_x", {24'h0, data_c}, 32'h00);
    @(posedge clk);
    #1;
    check("reg_en0_sel_x", {24'h0, data_r}, 32'h00);

    for (int j = 0; j < 8; j++) begin
      sub_en  = svecs[j].en;
      sub_sel = svecs[j].sel;
      #1;
      check($sformatf("sub_data[%0d]", j), {28'h0, sub_data}, {28'h0, svecs[j].exp});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_reg.md
DECODER_3TO8_REG -- requirements
Module: decoder_3to8_reg

Interface
REQ-001 Parameter OUT_REG, default 1: 1 means data is registered (1-cycle latency); 0 means data is combinational and the register stage is omitted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
REQ-004 en  input  1  decode enable; 0 forces all data outputs low.
REQ-005 s  input  3  select; s[2] is MSB.
REQ-006 data  output  8  one-hot decode; bit data[k] corresponds to s == k.
REQ-007 valid  output  1  high when data reflects a decode taken with en=1.
REQ-008 The block has one clock domain and no other ports.

Function
REQ-009 Decode rule: when en=1, data[k]=1 for k==s and all other bits are 0; when en=0, data=8'h00.
REQ-010 data is always one-hot or all-zero; no other pattern is legal in any cycle, including the cycle after reset deassertion.
REQ-011 OUT_REG=1: data and valid present the decode of the en and s values sampled at the previous rising clk edge (latency exactly 1 cycle, throughput 1 per cycle).
REQ-012 OUT_REG=0: data and valid follow en and s combinationally with zero cycles latency; reset has no effect on the outputs.
REQ-013 valid equals the en value the data was decoded from (registered alongside data when OUT_REG=1).
REQ-014 Changing s while en=1 updates data on the next edge (OUT_REG=1) with no intermediate pattern visible at the register output.
REQ-015 If s or en is X/Z, the output is don't-care, but it stays all-zero when en=0 is known.
REQ-016 Decode is built hierarchically: s[2] selects which of two 2-to-4 decoders is enabled (en & ~s[2] enables the low decoder for data[3:0]; en & s[2] enables the high decoder for data[7:4]). s[1:0] drives both sub-decoder selects.

Reset
REQ-017 OUT_REG=1: when reset=1 at a rising clk edge, data <= 8'h00 and valid <= 0, regardless of en and s.
REQ-018 Reset takes priority over a simultaneous en=1; the first post-reset decode appears one cycle after the first edge with reset=0 and en=1.
REQ-019 Asserting reset mid-stream clears the outputs at that edge; in-flight decodes are discarded.
REQ-020 Before the first reset edge, output state is undefined. The bench applies reset for at least 1 cycle.

Structure
REQ-021 A shared package decoder_pkg holds constants SEL_W=3 and OUT_W=8, plus the typedef onehot8_t (logic [7:0]).
REQ-022 One sub-module, decoder_2to4, provides the low and high decodes:
- ports: en (1), select (2), data (4)
- fully combinational, no clock
- data[select]=en, all other bits 0
REQ-023 decoder_3to8_reg instantiates decoder_2to4 exactly twice and adds an optional output register stage controlled by a generate on OUT_REG.

Verification
REQ-024 Reset: reset=1 with en=1, s=3'd5 for 2 cycles -> data=8'h00, valid=0 every cycle.
REQ-025 Sweep: en=1, s = 0..7, one value per cycle -> data one cycle later is 8'h01, 02, 04, 08, 10, 20, 40, 80 in order, valid=1 throughout.
REQ-026 Disable: en=0, s=3'd6 -> data=8'h00 and valid=0 on the next cycle; then en=1 -> data=8'h40.
REQ-027 Mid-stream reset: en=1, s=3'd7 for 1 cycle, then reset=1 for 1 cycle -> data goes 8'h80 then 8'h00, and resumes on the cycle after reset deasserts.
REQ-028 Sub-module: decoder_2to4 with en=1, select=0..3 -> data=4'b0001, 0010, 0100, 1000; with en=0 -> 4'b0000 for every select value.
REQ-029 OUT_REG=0 build: en=1, s=3'd3 -> data=8'h08 in the same delta cycle, independent of clk and reset.
